sram_frame_reader: RTL and testbench

- Read-side counterpart of the SRAM fill/test writer. Streams one frame of 16-bit pixel words out of external SRAM through the existing sram_controller read port, starting at BASE_ADDR.
- Issues back-to-back read requests and tracks in-flight reads. Buffers returned words in a show-ahead FIFO.
- Delivers pixels to the VGA pixel pipeline over a valid/ready interface. Restarts on every frame_start pulse.

---
 rtl/vga_sram_pkg.sv | 17 +
 rtl/sync_fifo_sa.sv | 53 +++++
 rtl/sram_frame_reader.sv | 110 +++++++++++
 tb/tb_sram_frame_reader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sram_pkg.sv
// Shared SRAM/VGA definitions: bus widths, reader state encoding and default frame geometry.
package vga_sram_pkg;

  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 16;

  localparam int FRAME_W_DEFAULT     = 320;
  localparam int FRAME_H_DEFAULT     = 240;
  localparam int FRAME_WORDS_DEFAULT = FRAME_W_DEFAULT * FRAME_H_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: head word is visible whenever the FIFO is not empty.
module sync_fifo_sa #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero while empty so downstream never sees stale words.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_frame_reader.sv
// Streams one frame of pixel words from SRAM into a show-ahead FIFO feeding the VGA pipeline.
module sram_frame_reader
  import vga_sram_pkg::*;
#(
  parameter logic [SRAM_ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                     FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int                     RD_LATENCY  = 2,
  parameter int                     FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   rd_gnt,
  output logic                   rd_req,
  output logic [SRAM_ADDR_W-1:0] read_addr,
  input  logic [SRAM_DATA_W-1:0] read_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [SRAM_DATA_W-1:0] pix_data,
  output logic                   frame_done,
  output logic                   underflow,
  output rd_state_t              dbg_state
);

  localparam int CNT_W  = SRAM_ADDR_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FRAME_WORDS_C = CNT_W'(FRAME_WORDS);

  // Handshakes: a read transfers when rd_req & rd_gnt are both high at a clock
  // edge; a pixel transfers when pix_valid & pix_ready are both high at an edge.
  rd_state_t             state;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      pop_cnt;
  logic [RD_LATENCY-1:0] pipe;
  logic [FCNT_W-1:0]     inflight_cnt;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  accept;
  logic                  ret;
  logic                  push;
  logic                  pop;

  // Words in the FIFO plus words still in flight reserve FIFO space, so returns never overflow.
  assign rd_req     = (state == ST_FETCH) && (issue_cnt < FRAME_WORDS_C) &&
                      ((fifo_count + inflight_cnt) < FCNT_W'(FIFO_DEPTH));
  assign accept     = rd_req & rd_gnt;
  assign ret        = pipe[RD_LATENCY-1];
  assign push       = ret & ~frame_start;
  assign pix_valid  = ~fifo_empty;
  assign pop        = pix_valid & pix_ready & ~frame_start;
  assign frame_done = (state == ST_DRAIN) & pop & (pop_cnt == FRAME_WORDS_C - CNT_W'(1));
  assign dbg_state  = state;

  sync_fifo_sa #(
    .WIDTH (SRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (frame_start),
    .push      (push),
    .push_data (read_data),
    .pop       (pop),
    .head      (pix_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      read_addr    <= BASE_ADDR;
      issue_cnt    <= '0;
      pop_cnt      <= '0;
      pipe         <= '0;
      inflight_cnt <= '0;
      underflow    <= 1'b0;
    end else begin
      if (state == ST_FETCH && pix_ready && !pix_valid) underflow <= 1'b1;
      if (frame_start) begin
        state        <= ST_FETCH;
        read_addr    <= BASE_ADDR;
        issue_cnt    <= '0;
        pop_cnt      <= '0;
        pipe         <= '0;
        inflight_cnt <= '0;
      end else begin
        for (int i = RD_LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0]      <= accept;
        inflight_cnt <= inflight_cnt + FCNT_W'(accept) - FCNT_W'(ret);
        if (accept) begin
          read_addr <= read_addr + SRAM_ADDR_W'(1);
          issue_cnt <= issue_cnt + CNT_W'(1);
        end
        if (pop) pop_cnt <= pop_cnt + CNT_W'(1);
        case (state)
          ST_FETCH: if (accept && issue_cnt == FRAME_WORDS_C - CNT_W'(1)) state <= ST_DRAIN;
          ST_DRAIN: if (frame_done) state <= ST_IDLE;
          default:  ;
        endcase
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader with a cycle-level SRAM model and a frame-level reference model.
module tb_sram_frame_reader;
  import vga_sram_pkg::*;

  localparam int FW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam logic [18:0] BASE = 19'd0;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        rd_gnt;
  logic        rd_req;
  logic [18:0] read_addr;
  logic [15:0] read_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        frame_done;
  logic        underflow;
  rd_state_t   dbg_state;

  sram_frame_reader #(
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW),
    .RD_LATENCY  (LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .rd_gnt      (rd_gnt),
    .rd_req      (rd_req),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .frame_done  (frame_done),
    .underflow   (underflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- check bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [15:0] exp_q[$];
  int          avail_q[$];
  bit          m_active;
  int          m_issued;
  int          m_popped;
  bit          m_uf;
  logic [18:0] sram_addr_q[$];
  int          sram_due_q[$];

  int          n_acc, n_done, first_req, last_req, first_valid;
  logic [15:0] pop_log[$];

  rd_state_t   e_state;
  bit          e_req, e_valid, e_pop, e_done;

  // Frame-level expectation: word k of a frame is BASE+k, poppable LAT+1 cycles after its accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_issued = 0;
      m_popped = 0;
      m_uf     = 1'b0;
      exp_q.delete();
      avail_q.delete();
      sram_addr_q.delete();
      sram_due_q.delete();
      read_data = 16'h0;
    end else begin
      e_state = !m_active ? ST_IDLE : ((m_issued < FW) ? ST_FETCH : ST_DRAIN);
      e_req   = (e_state == ST_FETCH) && ((m_issued - m_popped) < DEPTH);
      e_valid = (avail_q.size() > 0) && (avail_q[0] <= cyc);
      e_pop   = e_valid && pix_ready;
      e_done  = e_pop && (m_popped == FW - 1) && !frame_start;

      chk("state", 32'(dbg_state), 32'(e_state));
      chk("rd_req", 32'(rd_req), 32'(e_req));
      if (e_req) chk("read_addr", 32'(read_addr), 32'(BASE) + 32'(m_issued));
      chk("pix_valid", 32'(pix_valid), 32'(e_valid));
      if (e_valid) chk("pix_data", 32'(pix_data), 32'(exp_q[0]));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("underflow", 32'(underflow), 32'(m_uf));

      if (rd_req) begin
        if (first_req < 0) first_req = cyc;
        last_req = cyc;
      end
      if (pix_valid && first_valid < 0) first_valid = cyc;
      if (rd_req && rd_gnt) begin
        n_acc++;
        sram_addr_q.push_back(read_addr);
        sram_due_q.push_back(cyc + LAT);
      end
      if (frame_done) n_done++;
      if (frame_start) pop_log.delete();
      else if (pix_valid && pix_ready) pop_log.push_back(pix_data);

      if (e_state == ST_FETCH && pix_ready && !e_valid) m_uf = 1'b1;
      if (frame_start) begin
        m_active = 1'b1;
        m_issued = 0;
        m_popped = 0;
        exp_q.delete();
        avail_q.delete();
      end else begin
        if (e_req && rd_gnt) begin
          exp_q.push_back(16'(32'(BASE) + 32'(m_issued)));
          avail_q.push_back(cyc + LAT + 1);
          m_issued++;
        end
        if (e_pop) begin
          void'(exp_q.pop_front());
          void'(avail_q.pop_front());
          m_popped++;
          if (m_popped == FW) m_active = 1'b0;
        end
      end

      // SRAM answers every accepted read after LAT cycles, regardless of frame restarts.
      if (sram_due_q.size() > 0 && sram_due_q[0] == cyc) begin
        read_data = sram_addr_q[0][15:0];
        void'(sram_addr_q.pop_front());
        void'(sram_due_q.pop_front());
      end else begin
        read_data = 16'hBEEF;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_stats();
    n_acc       = 0;
    n_done      = 0;
    first_req   = -1;
    last_req    = -1;
    first_valid = -1;
    pop_log.delete();
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (n_done < 1 && k < budget) begin
      step(1);
      k++;
    end
    chk(name, 32'(n_done >= 1), 32'd1);
  endtask

  task automatic check_log(input string name);
    chk(name, 32'(pop_log.size()), 32'(FW));
    for (int i = 0; i < FW && i < pop_log.size(); i++)
      chk(name, 32'(pop_log[i]), 32'(i));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    rd_gnt      = 1'b0;
    pix_ready   = 1'b0;
    read_data   = 16'h0;
    reset_stats();
    step(3);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_read_addr", 32'(read_addr), 32'(BASE));
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    step(2);

    // Full-rate frame; pix_ready high before data arrives also raises underflow.
    reset_stats();
    rd_gnt    = 1'b1;
    pix_ready = 1'b1;
    pulse_start();
    wait_done(60, "t1_done");
    step(2);
    check_log("t1_pixels");
    chk("t1_accepts", 32'(n_acc), 32'd8);
    chk("t1_done_count", 32'(n_done), 32'd1);
    chk("t1_req_span", 32'(last_req - first_req), 32'd7);
    chk("t1_latency", 32'(first_valid - first_req), 32'd3);
    chk("t1_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t1_underflow", 32'(underflow), 32'd1);

    // Consumer stalled: only DEPTH reads may be issued.
    reset_stats();
    pix_ready = 1'b0;
    pulse_start();
    step(10);
    chk("t2_accepts", 32'(n_acc), 32'd4);
    chk("t2_rd_req", 32'(rd_req), 32'd0);
    chk("t2_pix_valid", 32'(pix_valid), 32'd1);
    chk("t2_head", 32'(pix_data), 32'd0);
    pix_ready = 1'b1;
    wait_done(60, "t2_done");
    check_log("t2_pixels");
    chk("t2_accepts_all", 32'(n_acc), 32'd8);

    // Grant toggling every cycle.
    reset_stats();
    pulse_start();
    for (int k = 0; k < 80 && n_done < 1; k++) begin
      rd_gnt = ~rd_gnt;
      step(1);
    end
    chk("t3_done", 32'(n_done), 32'd1);
    rd_gnt = 1'b1;
    check_log("t3_pixels");
    chk("t3_accepts", 32'(n_acc), 32'd8);

    // Restart after five pops with reads still in flight.
    reset_stats();
    pulse_start();
    for (int k = 0; k < 40 && pop_log.size() < 5; k++) step(1);
    chk("t4_five_popped", 32'(pop_log.size()), 32'd5);
    chk("t4_no_early_done", 32'(n_done), 32'd0);
    pulse_start();
    wait_done(60, "t4_done");
    step(2);
    check_log("t4_pixels");
    chk("t4_done_count", 32'(n_done), 32'd1);
    chk("t4_underflow_sticky", 32'(underflow), 32'd1);

    // Asynchronous reset while draining.
    reset_stats();
    pulse_start();
    for (int k = 0; k < 30 && dbg_state != ST_DRAIN; k++) step(1);
    chk("t6_in_drain", 32'(dbg_state), 32'(ST_DRAIN));
    chk("t6_valid_before", 32'(pix_valid), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_req", 32'(rd_req), 32'd0);
    chk("t6_read_addr", 32'(read_addr), 32'(BASE));
    chk("t6_pix_valid", 32'(pix_valid), 32'd0);
    chk("t6_pix_data", 32'(pix_data), 32'd0);
    chk("t6_frame_done", 32'(frame_done), 32'd0);
    chk("t6_underflow", 32'(underflow), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("t6_idle_after", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_valid_after", 32'(pix_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
